instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage RV32I pipeline. Owns the PC register, drives the instruction-memory request handshake, and contains the IF/ID pipeline register that feeds instruction decode.
- Obeys the stall controls (pc_load, if_id_load) produced by the hazard unit in ID.
- Obeys the branch redirect/flush from EX.
- Uses a one-entry hold buffer so a fetched word is never lost during a stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush/empty.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pc_load  in  1  from hazard unit; 1 = PC may advance.
- if_id_load  in  1  from hazard unit; 1 = IF/ID register may update.
- branch_taken  in  1  from EX; redirect and flush, highest priority.
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address.
- imem_rdata  in  32  fetched word; valid when imem_ready=1.
- imem_ready  in  1  response strobe; may assert in the same cycle as req or any later cycle.
- instruction  out  32  IF/ID instruction (to ID).
- pc_out  out  32  IF/ID PC of that instruction.
- valid_out  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (reset=0, async), all values forced while low:
  - pc=RESET_PC; state=START; instruction=NOP_INSTR; pc_out=32'h0; valid_out=0.
  - hold buffer empty; imem_req=0; imem_addr=RESET_PC.
- Handshake rules:
  - imem_addr=pc except in DRAIN.
  - A request is in flight when imem_req=1 and imem_ready=0 at a clock edge.
  - While in flight, imem_req and imem_addr stay stable until imem_ready=1.
  - Memory never withdraws a response.
- FSM states: START, FETCH, HOLD, DRAIN.
- START: imem_req=0; go to FETCH the next cycle. This is one idle cycle after reset release.
- FETCH: imem_req=1.
  - imem_ready=1 and if_id_load=1 and pc_load=1: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4; stay in FETCH. Throughput is 1 instr/cycle with a zero-wait memory.
  - imem_ready=1 and (if_id_load=0 or pc_load=0): capture imem_rdata and pc in the hold buffer; IF/ID unchanged; PC unchanged; go to HOLD.
  - imem_ready=0 and if_id_load=1: IF/ID <= bubble (NOP_INSTR, valid=0, pc_out unchanged).
  - imem_ready=0 and if_id_load=0: IF/ID holds.
- HOLD: imem_req=0.
  - When if_id_load=1 and pc_load=1: IF/ID <= buffer contents, valid=1; pc <= pc+4; buffer emptied; go to FETCH.
  - Otherwise hold everything.
- branch_taken=1 at an edge, overrides every rule above:
  - IF/ID <= bubble regardless of if_id_load.
  - hold buffer cleared.
  - pc <= {branch_target[31:2],2'b00}.
  - If a request is in flight (FETCH, req=1, ready=0): go to DRAIN.
  - Otherwise go to FETCH.
- DRAIN: imem_req=1 with the old address (latched in an internal register) until imem_ready=1.
  - The response is discarded.
  - Then go to FETCH at the redirected pc.
  - A second branch_taken in DRAIN updates pc only.
- branch_taken in the same cycle as imem_ready=1 in FETCH: the branch wins; the returned word is dropped; go to FETCH (nothing is in flight).
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Latency: an instruction appears on IF/ID outputs the edge after imem_ready=1 with no stall.
- Reset asserted mid-transaction: everything is cleared immediately. An outstanding memory response after release is ignored only if it arrives during START (START ignores imem_ready).

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning addr-based words, no stalls -> START 1 cycle; then pc_out = 0,4,8 on consecutive cycles; valid_out=1; instruction matches imem_rdata.
- Memory with 2 wait states, no stalls -> imem_addr stable during the wait; IF/ID shows NOP_INSTR with valid_out=0 on wait cycles; each real instruction is valid for one cycle.
- Stall: hold pc_load=0 and if_id_load=0 for 3 cycles while word 0xABCD0123 at pc=8 returns -> HOLD entered with imem_req=0; on release, instruction=0xABCD0123 and pc_out=8, with no duplicate and no loss; the next fetch is from 0xC.
- branch_taken with target 0x102 while idle-ready -> next imem_addr=0x100; IF/ID is a bubble (valid_out=0); the next valid instruction has pc_out=0x100.
- branch_taken during an in-flight request at 0x20 (ready delayed 2 cycles), target 0x80 -> DRAIN keeps addr 0x20 until ready; the 0x20 data never reaches IF/ID; the next request is at 0x80.
- pc=32'hFFFF_FFFC fetched with no stall -> next imem_addr=0; reset pulsed mid-wait -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch handshake between the IF stage and imem.
// The IF stage is the master; the memory model or bus port is the slave.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I IF stage: PC register, imem request FSM, one-entry hold buffer
// and the IF/ID pipeline register.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pc_load,
  input  logic                 if_id_load,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  instruction_fetch_if.master  imem,
  output logic [31:0]          instruction,
  output logic [31:0]          pc_out,
  output logic                 valid_out
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  if_id_t      if_id;
  if_id_t      hold_q;

  logic        go;
  logic        ready;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign go     = pc_load & if_id_load;
  assign ready  = imem.imem_ready;
  assign pc_inc = pc + 32'd4;
  assign target = {branch_target[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= START;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      if_id      <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      hold_q     <= '0;
    end else if (branch_taken) begin
      if_id.instr <= NOP_INSTR;
      if_id.valid <= 1'b0;
      hold_q      <= '0;
      pc          <= target;
      // An unanswered request must still be drained at its old address
      unique case (state)
        FETCH: begin
          if (!ready) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
        end
        DRAIN: begin
          if (ready) state <= FETCH;
        end
        START,
        HOLD: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        START: state <= FETCH;
        FETCH: begin
          unique case (1'b1)
            ready & go: begin
              if_id <= '{pc: pc, instr: imem.imem_rdata, valid: 1'b1};
              pc    <= pc_inc;
            end
            ready & ~go: begin
              hold_q <= '{pc: pc, instr: imem.imem_rdata, valid: 1'b1};
              state  <= HOLD;
            end
            ~ready & if_id_load: begin
              if_id.instr <= NOP_INSTR;
              if_id.valid <= 1'b0;
            end
            default: ;
          endcase
        end
        HOLD: begin
          if (go) begin
            if_id        <= hold_q;
            hold_q.valid <= 1'b0;
            pc           <= pc_inc;
            state        <= FETCH;
          end
        end
        DRAIN: begin
          if (ready) state <= FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

  assign instruction = if_id.instr;
  assign pc_out      = if_id.pc;
  assign valid_out   = if_id.valid;

endmodule
